// File: rtl/score_display.sv
`default_nettype none
// ============================================================================
// Module      : score_display
// Description : Resynchronises the 7-bit running score into the clk domain,
//               converts it to BCD with a sequential shift-and-add-3 engine
//               and time-multiplexes the digits onto a 4-digit common-anode
//               seven-segment display.
//               Optional build macro: SCORE_SIGNED_EN (two's complement score,
//               minus sign on digit2, magnitude on digit1/digit0).
// Ports       : clk   - system clock, rising edge
//               rst   - asynchronous active-high reset
//               score - score value, may change asynchronously to clk
//               an    - anode enables, active-low, an[0] rightmost digit
//               seg   - cathodes {g,f,e,d,c,b,a}, active-low
//               dp    - decimal point, active-low, held off
//               upd   - one-cycle pulse when new digits are latched
// Revision    : 1.0 - initial release
// ============================================================================
module score_display #(
    parameter int REFRESH_BITS = 18
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] score,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       upd
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SHIFT  = 2'd1;
    localparam logic [1:0] c_ST_UPDATE = 2'd2;

    localparam logic [6:0] c_SEG_BLANK = 7'b1111111;
    localparam logic [6:0] c_SEG_DASH  = 7'b0111111;

    logic [6:0]              r_s1, r_s2, r_last;
    logic [1:0]              r_state, w_state_next;
    logic [2:0]              r_i;
    logic [6:0]              r_shift;
    logic [11:0]             r_bcd;
    logic [3:0]              r_disp_h, r_disp_t, r_disp_o;
    logic [REFRESH_BITS-1:0] r_cnt;
    logic                    r_upd;
    logic [3:0]              r_an;
    logic [6:0]              r_seg;

    logic                    w_eligible, w_load, w_shift, w_latch;
    logic [6:0]              w_mag;
    logic [11:0]             w_adj;
    logic [1:0]              w_sel;
    logic [6:0]              w_seg_next;
    logic                    w_show_tens;

`ifdef SCORE_SIGNED_EN
    logic                    r_neg, r_disp_neg;
    // -64 negates to 7'b1000000, which is the correct magnitude 64.
    assign w_mag = r_s2[6] ? (~r_s2 + 7'd1) : r_s2;
`else
    assign w_mag = r_s2;
`endif

    function automatic logic [6:0] f_seg7(input logic [3:0] d);
        case (d)
            4'd0:    f_seg7 = 7'b1000000;
            4'd1:    f_seg7 = 7'b1111001;
            4'd2:    f_seg7 = 7'b0100100;
            4'd3:    f_seg7 = 7'b0110000;
            4'd4:    f_seg7 = 7'b0011001;
            4'd5:    f_seg7 = 7'b0010010;
            4'd6:    f_seg7 = 7'b0000010;
            4'd7:    f_seg7 = 7'b1111000;
            4'd8:    f_seg7 = 7'b0000000;
            4'd9:    f_seg7 = 7'b0010000;
            default: f_seg7 = c_SEG_BLANK;
        endcase
    endfunction

    function automatic logic [3:0] f_add3(input logic [3:0] n);
        f_add3 = (n >= 4'd5) ? (n + 4'd3) : n;
    endfunction

    // Only convert a value that has been stable for two samples and that
    // differs from what is already on the display.
    assign w_eligible = (r_s1 == r_s2) && (r_s2 != r_last);
    assign w_adj      = {f_add3(r_bcd[11:8]), f_add3(r_bcd[7:4]), f_add3(r_bcd[3:0])};

    // ------------------------------------------------------------------------
    // Conversion FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_latch      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_eligible) begin
                    w_load       = 1'b1;
                    w_state_next = c_ST_SHIFT;
                end
            end
            c_ST_SHIFT: begin
                w_shift = 1'b1;
                if (r_i == 3'd6) w_state_next = c_ST_UPDATE;
            end
            c_ST_UPDATE: begin
                w_latch      = 1'b1;
                w_state_next = c_ST_IDLE;
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Synchroniser and conversion datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1     <= '0;
            r_s2     <= '0;
            r_last   <= '0;
            r_i      <= '0;
            r_shift  <= '0;
            r_bcd    <= '0;
            r_disp_h <= '0;
            r_disp_t <= '0;
            r_disp_o <= '0;
            r_upd    <= 1'b0;
`ifdef SCORE_SIGNED_EN
            r_neg      <= 1'b0;
            r_disp_neg <= 1'b0;
`endif
        end else begin
            r_s1  <= score;
            r_s2  <= r_s1;
            r_upd <= w_latch;
            if (w_load) begin
                r_shift <= w_mag;
                r_bcd   <= '0;
                r_last  <= r_s2;
                r_i     <= '0;
`ifdef SCORE_SIGNED_EN
                r_neg   <= r_s2[6];
`endif
            end
            if (w_shift) begin
                // Adjust then shift the combined {bcd, binary} register by one.
                r_bcd   <= {w_adj[10:0], r_shift[6]};
                r_shift <= {r_shift[5:0], 1'b0};
                r_i     <= r_i + 3'd1;
            end
            if (w_latch) begin
                r_disp_h <= r_bcd[11:8];
                r_disp_t <= r_bcd[7:4];
                r_disp_o <= r_bcd[3:0];
`ifdef SCORE_SIGNED_EN
                r_disp_neg <= r_neg;
`endif
            end
        end
    end

    // ------------------------------------------------------------------------
    // Display refresh
    // ------------------------------------------------------------------------
    assign w_sel = r_cnt[REFRESH_BITS-1 -: 2];

    // In the signed build the hundreds nibble is always zero, so this reduces
    // to "tens non-zero".
    assign w_show_tens = (r_disp_h != 4'd0) || (r_disp_t != 4'd0);

    always_comb begin
        w_seg_next = c_SEG_BLANK;
        case (w_sel)
            2'd0: w_seg_next = f_seg7(r_disp_o);
            2'd1: w_seg_next = w_show_tens ? f_seg7(r_disp_t) : c_SEG_BLANK;
`ifdef SCORE_SIGNED_EN
            2'd2: w_seg_next = r_disp_neg ? c_SEG_DASH : c_SEG_BLANK;
`else
            2'd2: w_seg_next = (r_disp_h != 4'd0) ? f_seg7(r_disp_h) : c_SEG_BLANK;
`endif
            default: w_seg_next = c_SEG_BLANK;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_an  <= 4'b1111;
            r_seg <= c_SEG_BLANK;
        end else begin
            r_cnt <= r_cnt + REFRESH_BITS'(1);
            r_an  <= ~(4'b0001 << w_sel);
            r_seg <= w_seg_next;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign upd = r_upd;
    assign dp  = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_score_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_score_display
// Description : Self-checking bench for score_display (REFRESH_BITS = 4).
//               Expected digit patterns are queued when a score is applied and
//               compared when the DUT pulses upd.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_score_display;

    localparam int REFRESH_BITS = 4;
    localparam logic [6:0] c_BLANK = 7'b1111111;
    localparam logic [6:0] c_ZERO  = 7'b1000000;

    logic       clk;
    logic       rst;
    logic [6:0] score;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       upd;

    int n_total;
    int n_pass;
    logic [27:0] q_exp[$];

    score_display #(.REFRESH_BITS(REFRESH_BITS)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .score (score),
        .an    (an),
        .seg   (seg),
        .dp    (dp),
        .upd   (upd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [6:0] seg_code(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return c_BLANK;
        endcase
    endfunction

    // {digit3, digit2, digit1, digit0}
    function automatic logic [27:0] exp_pattern(input int v);
        logic [6:0] d2, d1, d0;
`ifdef SCORE_SIGNED_EN
        int sv, mag;
        sv  = (v >= 64) ? v - 128 : v;
        mag = (sv < 0) ? -sv : sv;
        d2  = (sv < 0) ? 7'b0111111 : c_BLANK;
        d1  = ((mag / 10) != 0) ? seg_code(mag / 10) : c_BLANK;
        d0  = seg_code(mag % 10);
`else
        int h, t;
        h  = v / 100;
        t  = (v / 10) % 10;
        d2 = (h != 0) ? seg_code(h) : c_BLANK;
        d1 = (h != 0 || t != 0) ? seg_code(t) : c_BLANK;
        d0 = seg_code(v % 10);
`endif
        return {c_BLANK, d2, d1, d0};
    endfunction

    // Observe one full refresh period and collect what each digit shows.
    task automatic sweep(output logic [27:0] got);
        got = '0;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); @(negedge clk);
            case (an)
                4'b1110: got[6:0]   = seg;
                4'b1101: got[13:7]  = seg;
                4'b1011: got[20:14] = seg;
                4'b0111: got[27:21] = seg;
                default: ;
            endcase
        end
    endtask

    // Wait for upd, check latency, then pop and compare the displayed digits.
    task automatic wait_upd(input string tag, input int exp_lat, input int used);
        int n;
        bit found;
        logic [27:0] got, exp;
        n = used;
        found = 0;
        while (n < 40 && !found) begin
            @(posedge clk); @(negedge clk);
            n++;
            if (upd === 1'b1) found = 1;
        end
        check({tag, "_lat"}, n, exp_lat);
        exp = q_exp.pop_front();
        if (found) begin
            @(posedge clk); @(negedge clk);
            check({tag, "_pulse"}, upd, 1'b0);
            sweep(got);
            check({tag, "_disp"}, got, exp);
        end
    endtask

    task automatic apply(input string tag, input int v);
        score = 7'(v);
        q_exp.push_back(exp_pattern(v));
        wait_upd(tag, 11, 0);
    endtask

    initial begin
        logic [27:0] got;
        logic [3:0]  an_exp;
        int          n_upd;
        int          prev, v;

        n_total = 0;
        n_pass  = 0;
        rst     = 1'b1;
        score   = 7'd0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_an", an, 4'b1111);
        check("rst_seg", seg, c_BLANK);
        check("rst_dp", dp, 1'b1);
        check("rst_upd", upd, 1'b0);

        // Refresh sequence after release: "0" on digit0, others blank
        rst = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); @(negedge clk);
            an_exp = ~(4'b0001 << (k / 4));
            check($sformatf("refresh_an%0d", k), an, an_exp);
            check($sformatf("refresh_seg%0d", k), seg, (k < 4) ? c_ZERO : c_BLANK);
        end

        apply("s127", 127);
        apply("s5", 5);
        apply("s10", 10);
        apply("s125", 125);

        // Unstable input: no conversion, display keeps the last value
        n_upd = 0;
        got   = '0;
        for (int k = 0; k < 20; k++) begin
            score = (k % 2 == 0) ? 7'd4 : 7'd3;
            @(posedge clk); @(negedge clk);
            if (upd === 1'b1) n_upd++;
            case (an)
                4'b1110: got[6:0]   = seg;
                4'b1101: got[13:7]  = seg;
                4'b1011: got[20:14] = seg;
                4'b0111: got[27:21] = seg;
                default: ;
            endcase
        end
        check("toggle_noupd", n_upd, 0);
        check("toggle_disp", got, exp_pattern(125));
        apply("hold4", 4);

        // Reset in the middle of converting 99
        score = 7'd99;
        n_upd = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); @(negedge clk);
            if (upd === 1'b1) n_upd++;
        end
        rst = 1'b1;
        #1;
        check("midrst_an", an, 4'b1111);
        check("midrst_seg", seg, c_BLANK);
        check("midrst_upd", upd, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        q_exp.push_back(exp_pattern(99));
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); @(negedge clk);
            if (upd === 1'b1) n_upd++;
            check($sformatf("postrst_seg%0d", k), seg, c_ZERO);
        end
        check("midrst_noupd", n_upd, 0);
        wait_upd("s99", 11, 4);

        // A few random values
        prev = 99;
        for (int k = 0; k < 4; k++) begin
            v = int'($urandom_range(0, 127));
            if (v == prev) v = (v + 1) % 128;
            apply($sformatf("rnd%0d_%0d", k, v), v);
            prev = v;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
